// File: rtl/tree_node_pkg.sv
// Shared types and helpers for the tree node dispatcher and its arbiters.
package tree_node_pkg;

  // Per-child channel state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_PEND = 2'd2
  } child_state_t;

  // Arbitration modes shared by the dispatch and return arbiters.
  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Number of set bits in a vector of up to 16 children.
  function automatic int popcount(input logic [15:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) c = c + 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/tree_rr_arbiter.sv
// Round-robin or fixed-priority arbiter with a registered search pointer.
// In round-robin mode the search starts at the pointer, and the pointer moves
// to the slot after the winner on every advance. In fixed mode index 0 always
// has top priority and the pointer is not used.
module tree_rr_arbiter
  import tree_node_pkg::*;
#(
  parameter int N     = 5,
  parameter int MODE  = ARB_RR,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant_onehot,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx;
  logic             found;
  int               j;

  // Scan the requests starting at the pointer (or at 0) and take the first hit.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    idx          = '0;
    j            = 0;
    for (int i = 0; i < N; i++) begin
      j = (MODE == ARB_FIXED) ? i : int'(ptr) + i;
      if (j >= N) j = j - N;
      idx = IDX_W'(j);
      if (!found && req[idx]) begin
        found             = 1'b1;
        grant_onehot[idx] = 1'b1;
        grant_idx         = idx;
      end
    end
  end

  // Move the pointer past the winner when the grant is actually used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (MODE == ARB_RR && advance && found) begin
      ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/tree_node_dispatcher.sv
// Job dispatcher node: hands accepted jobs to idle children and returns their
// results in arbitrated order.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high. in_ready depends only on registered child state, never on
// in_valid. Once out_valid is high it stays high with out_data/out_tag/
// out_child unchanged until out_ready is seen high.
module tree_node_dispatcher
  import tree_node_pkg::*;
#(
  parameter int N_CHILD  = 5,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 4,
  parameter int ARB_MODE = ARB_RR,
  parameter int CIDX_W   = $clog2(N_CHILD)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [TAG_W-1:0]          in_tag,
  output logic [N_CHILD-1:0]        ch_start,
  output logic [N_CHILD*DATA_W-1:0] ch_data,
  input  logic [N_CHILD-1:0]        ch_done,
  input  logic [N_CHILD*DATA_W-1:0] ch_result,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [TAG_W-1:0]          out_tag,
  output logic [CIDX_W-1:0]         out_child,
  output logic [CIDX_W:0]           busy_cnt,
  output logic [15:0]               jobs_done,
  output logic                      err
);

  child_state_t      child_state [N_CHILD];
  logic [TAG_W-1:0]  tag_q       [N_CHILD];
  logic [DATA_W-1:0] res_q       [N_CHILD];

  logic [N_CHILD-1:0] idle_vec, busy_vec, pend_vec;
  logic [N_CHILD-1:0] disp_onehot, ret_onehot, ret_req, lock_mask;
  logic [CIDX_W-1:0]  disp_idx, ret_idx, ret_lock_idx;
  logic               ret_lock;
  logic               accept, out_fire;
  logic [15:0]        active16;

  // Decode child states into request vectors and the active count.
  always_comb begin
    idle_vec = '0;
    busy_vec = '0;
    pend_vec = '0;
    active16 = '0;
    for (int k = 0; k < N_CHILD; k++) begin
      idle_vec[k] = (child_state[k] == ST_IDLE);
      busy_vec[k] = (child_state[k] == ST_BUSY);
      pend_vec[k] = (child_state[k] == ST_PEND);
    end
    active16[N_CHILD-1:0] = ~idle_vec;
    busy_cnt = (CIDX_W+1)'(popcount(active16));
  end

  assign in_ready = |idle_vec;
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // While a stalled result is on the port, only that child may be selected.
  always_comb begin
    lock_mask               = '0;
    lock_mask[ret_lock_idx] = 1'b1;
    ret_req                 = ret_lock ? (pend_vec & lock_mask) : pend_vec;
  end

  tree_rr_arbiter #(.N(N_CHILD), .MODE(ARB_MODE), .IDX_W(CIDX_W)) u_disp_arb (
    .clk          (clk),
    .rst          (rst),
    .req          (idle_vec),
    .advance      (accept),
    .grant_onehot (disp_onehot),
    .grant_idx    (disp_idx)
  );

  tree_rr_arbiter #(.N(N_CHILD), .MODE(ARB_MODE), .IDX_W(CIDX_W)) u_ret_arb (
    .clk          (clk),
    .rst          (rst),
    .req          (ret_req),
    .advance      (out_fire),
    .grant_onehot (ret_onehot),
    .grant_idx    (ret_idx)
  );

  // Present the selected PEND child's result; zero when nothing is pending.
  always_comb begin
    out_valid = |pend_vec;
    out_child = out_valid ? ret_idx : '0;
    out_data  = out_valid ? res_q[ret_idx] : '0;
    out_tag   = out_valid ? tag_q[ret_idx] : '0;
  end

  // Per-child IDLE/BUSY/PEND state machines with their data, tag and result slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_start <= '0;
      ch_data  <= '0;
      for (int k = 0; k < N_CHILD; k++) begin
        child_state[k] <= ST_IDLE;
        tag_q[k]       <= '0;
        res_q[k]       <= '0;
      end
    end else begin
      ch_start <= accept ? disp_onehot : '0;
      for (int k = 0; k < N_CHILD; k++) begin
        case (child_state[k])
          ST_IDLE: begin
            if (accept && disp_idx == CIDX_W'(k)) begin
              child_state[k]                 <= ST_BUSY;
              ch_data[k*DATA_W +: DATA_W]    <= in_data;
              tag_q[k]                       <= in_tag;
            end
          end
          ST_BUSY: begin
            if (ch_done[k]) begin
              child_state[k] <= ST_PEND;
              res_q[k]       <= ch_result[k*DATA_W +: DATA_W];
            end
          end
          ST_PEND: begin
            if (out_fire && ret_onehot[k]) child_state[k] <= ST_IDLE;
          end
          default: child_state[k] <= ST_IDLE;
        endcase
      end
    end
  end

  // Sticky error, completion counter and the output-stall lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err          <= 1'b0;
      jobs_done    <= '0;
      ret_lock     <= 1'b0;
      ret_lock_idx <= '0;
    end else begin
      if (|(ch_done & ~busy_vec)) err <= 1'b1;
      if (out_fire) jobs_done <= jobs_done + 16'd1;
      if (out_valid && !out_ready) begin
        ret_lock     <= 1'b1;
        ret_lock_idx <= ret_idx;
      end else begin
        ret_lock     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tree_node_dispatcher.sv
// Bench for tree_node_dispatcher: one round-robin and one fixed-priority node,
// checked every cycle against a job-level reference model.
module tb_tree_node_dispatcher;

  localparam int N  = 5;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int CW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // index 0: round-robin node, index 1: fixed-priority node
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic [DW-1:0] in_data   [2];
  logic [TW-1:0] in_tag    [2];
  logic [N-1:0]  ch_start  [2];
  logic [N*DW-1:0] ch_data [2];
  logic [N-1:0]  ch_done   [2];
  logic [N*DW-1:0] ch_result [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic [DW-1:0] out_data  [2];
  logic [TW-1:0] out_tag   [2];
  logic [CW-1:0] out_child [2];
  logic [CW:0]   busy_cnt  [2];
  logic [15:0]   jobs_done [2];
  logic          err       [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    tree_node_dispatcher #(.N_CHILD(N), .DATA_W(DW), .TAG_W(TW), .ARB_MODE(g)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .in_tag    (in_tag[g]),
      .ch_start  (ch_start[g]),
      .ch_data   (ch_data[g]),
      .ch_done   (ch_done[g]),
      .ch_result (ch_result[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .out_tag   (out_tag[g]),
      .out_child (out_child[g]),
      .busy_cnt  (busy_cnt[g]),
      .jobs_done (jobs_done[g]),
      .err       (err[g])
    );
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [CW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic string nm(input string s, input int d);
    return $sformatf("%s_%s", (d == 0) ? "rr" : "fp", s);
  endfunction

  // ---------------- reference model ----------------
  // child status: 0 idle, 1 working, 2 result waiting
  int            m_st   [2][N];
  logic [DW-1:0] m_data [2][N];
  logic [DW-1:0] m_res  [2][N];
  logic [TW-1:0] m_tag  [2][N];
  logic [N-1:0]  m_start[2];
  int m_dptr[2], m_rptr[2], m_lock[2], m_jobs[2];
  bit m_err[2];

  task automatic model_reset(input int d);
    for (int k = 0; k < N; k++) begin
      m_st[d][k] = 0; m_data[d][k] = '0; m_res[d][k] = '0; m_tag[d][k] = '0;
    end
    m_start[d] = '0; m_dptr[d] = 0; m_rptr[d] = 0; m_lock[d] = -1;
    m_jobs[d] = 0; m_err[d] = 0;
  endtask

  // first child in status st, searching from ptr (round-robin) or from 0 (fixed)
  function automatic int pick(input int d, input int ptr, input int st);
    int start;
    start = (d == 1) ? 0 : ptr;
    for (int i = 0; i < N; i++) begin
      if (m_st[d][(start + i) % N] == st) return (start + i) % N;
    end
    return -1;
  endfunction

  function automatic int cur_sel(input int d);
    if (m_lock[d] >= 0) return m_lock[d];
    return pick(d, m_rptr[d], 2);
  endfunction

  task automatic model_step(input int d);
    int sel, g;
    bit any_idle;
    any_idle = 0;
    for (int k = 0; k < N; k++) if (m_st[d][k] == 0) any_idle = 1;
    sel = cur_sel(d);
    g   = (in_valid[d] && any_idle) ? pick(d, m_dptr[d], 0) : -1;
    for (int k = 0; k < N; k++) begin
      if (ch_done[d][k]) begin
        if (m_st[d][k] == 1) begin
          m_st[d][k]  = 2;
          m_res[d][k] = ch_result[d][k*DW +: DW];
        end else begin
          m_err[d] = 1;
        end
      end
    end
    if (sel >= 0 && out_ready[d]) begin
      m_st[d][sel] = 0;
      m_jobs[d]++;
      m_rptr[d] = (sel + 1) % N;
    end
    m_lock[d] = (sel >= 0 && !out_ready[d]) ? sel : -1;
    m_start[d] = '0;
    if (g >= 0) begin
      m_st[d][g]   = 1;
      m_data[d][g] = in_data[d];
      m_tag[d][g]  = in_tag[d];
      m_start[d][g] = 1'b1;
      m_dptr[d] = (g + 1) % N;
    end
  endtask

  task automatic check_outputs(input int d);
    int sel, nact;
    bit rdy;
    nact = 0; rdy = 0;
    for (int k = 0; k < N; k++) if (m_st[d][k] != 0) nact++; else rdy = 1;
    sel = cur_sel(d);
    check(nm("in_ready", d), in_ready[d], rdy);
    check(nm("ch_start", d), ch_start[d], m_start[d]);
    check(nm("busy_cnt", d), busy_cnt[d], nact);
    check(nm("jobs_done", d), jobs_done[d], m_jobs[d] % 65536);
    check(nm("err", d), err[d], m_err[d]);
    check(nm("out_valid", d), out_valid[d], sel >= 0);
    if (sel >= 0) begin
      check(nm("out_child", d), out_child[d], sel);
      check(nm("out_data", d), out_data[d], m_res[d][sel]);
      check(nm("out_tag", d), out_tag[d], m_tag[d][sel]);
    end
    for (int k = 0; k < N; k++)
      if (m_st[d][k] != 0) check(nm("ch_data", d), ch_data[d][k*DW +: DW], m_data[d][k]);
  endtask

  // ---------------- drivers ----------------
  task automatic clear_inputs(input int d);
    in_valid[d] = 0; in_data[d] = '0; in_tag[d] = '0;
    ch_done[d] = '0; ch_result[d] = '0; out_ready[d] = 0;
  endtask

  task automatic drive_random(input int d);
    in_valid[d]  = ($urandom_range(0, 3) != 0);
    in_data[d]   = $urandom;
    in_tag[d]    = TW'($urandom_range(0, 15));
    out_ready[d] = ($urandom_range(0, 2) != 0);
    ch_done[d]   = '0;
    for (int k = 0; k < N; k++) begin
      ch_result[d][k*DW +: DW] = $urandom;
      if (m_st[d][k] == 1 && $urandom_range(0, 3) == 0) ch_done[d][k] = 1'b1;
    end
  endtask

  // check both nodes, advance the model, then cross one clock edge
  task automatic tick();
    #1;
    for (int d = 0; d < 2; d++) check_outputs(d);
    if (out_valid[0] && out_ready[0] && exp_q.size() > 0)
      check("ret_order", out_child[0], exp_q.pop_front());
    for (int d = 0; d < 2; d++) model_step(d);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1;
    for (int d = 0; d < 2; d++) begin clear_inputs(d); model_reset(d); end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) check_outputs(d);
    rst = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    apply_reset();

    // five back-to-back jobs on the round-robin node
    for (int j = 0; j < 5; j++) begin
      in_valid[0] = 1; in_data[0] = 32'h100 + j; in_tag[0] = TW'(j + 1);
      for (int k = 0; k < N; k++) ch_result[0][k*DW +: DW] = 32'hA000 + k;
      tick();
      check("start_seq", ch_start[0], 5'b00001 << j);
    end
    in_valid[0] = 0;
    check("full_ready", in_ready[0], 0);

    // completions 3, 0, 4 one cycle apart, consumer always ready
    exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(4);
    out_ready[0] = 1;
    ch_done[0] = 5'b01000; tick();
    ch_done[0] = 5'b00001; tick();
    ch_done[0] = 5'b10000; tick();
    ch_done[0] = 5'b00000; tick(); tick();
    check("jobs_after3", jobs_done[0], 3);

    // two results stalled for ten cycles, then drained back to back
    out_ready[0] = 0;
    ch_done[0] = 5'b00110; tick();
    ch_done[0] = 5'b00000;
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", out_valid[0], 1);
      check("stall_child", out_child[0], 1);
      tick();
    end
    out_ready[0] = 1;
    exp_q.push_back(1); exp_q.push_back(2);
    tick(); tick();
    check("drain_left", exp_q.size(), 0);
    check("drain_valid", out_valid[0], 0);

    // fixed priority: free 1 and 3, then two jobs land on 1 then 3
    for (int j = 0; j < 5; j++) begin
      in_valid[1] = 1; in_data[1] = 32'h200 + j; in_tag[1] = TW'(j);
      tick();
    end
    in_valid[1] = 0; out_ready[1] = 1;
    ch_done[1] = 5'b01010; tick();
    ch_done[1] = 5'b00000; tick(); tick();
    in_valid[1] = 1; in_data[1] = 32'h300; in_tag[1] = 4'hC; tick();
    check("fp_first", ch_start[1], 5'b00010);
    in_data[1] = 32'h301; in_tag[1] = 4'hD; tick();
    check("fp_second", ch_start[1], 5'b01000);
    in_valid[1] = 0;

    // completion on an idle child is flagged and produces nothing
    ch_done[0] = 5'b00100; tick();
    ch_done[0] = 5'b00000;
    check("err_set", err[0], 1);
    check("err_novalid", out_valid[0], 0);
    tick(); tick(); tick();
    check("err_sticky", err[0], 1);

    // randomized traffic on both nodes
    for (int i = 0; i < 1500; i++) begin
      drive_random(0); drive_random(1);
      tick();
    end

    // drain everything, then start three jobs on the round-robin node
    for (int i = 0; i < 12; i++) begin
      for (int d = 0; d < 2; d++) begin
        in_valid[d] = 0; out_ready[d] = 1; ch_done[d] = '0;
        for (int k = 0; k < N; k++) if (m_st[d][k] == 1) ch_done[d][k] = 1'b1;
      end
      tick();
    end
    for (int d = 0; d < 2; d++) clear_inputs(d);
    for (int j = 0; j < 3; j++) begin
      in_valid[0] = 1; in_data[0] = 32'h400 + j; in_tag[0] = TW'(j + 5);
      tick();
    end
    in_valid[0] = 0;
    check("pre_rst_busy", busy_cnt[0], 3);

    // asynchronous reset in mid-cycle
    #2 rst = 1;
    model_reset(0); model_reset(1);
    #1;
    check("rst_start", ch_start[0], 0);
    check("rst_chdata", ch_data[0] == '0, 1);
    check("rst_valid", out_valid[0], 0);
    check("rst_data", out_data[0], 0);
    check("rst_tag", out_tag[0], 0);
    check("rst_child", out_child[0], 0);
    check("rst_busy", busy_cnt[0], 0);
    check("rst_jobs", jobs_done[0], 0);
    check("rst_err", err[0], 0);
    @(negedge clk);
    rst = 0;
    tick();
    check("post_rst_ready", in_ready[0], 1);

    // a late completion from an aborted job
    ch_done[0] = 5'b00001; tick();
    ch_done[0] = 5'b00000; tick();
    check("late_done_err", err[0], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tree_node_dispatcher.md
# tree_node_dispatcher

Parametrised hierarchy node for the generated module tree. It replaces the fixed, port-less fan-out node with a live job dispatcher over `N_CHILD` child channels. Jobs arrive on a valid/ready port and are dispatched to idle children by a configurable arbiter. Child completions are collected and returned in arbitrated order on a second valid/ready port. Nodes cascade: a node's child port may drive another `tree_node_dispatcher`.

## Interface
Clock is `clk`; reset is `rst`, asynchronous and active-high.

Parameters:
- `N_CHILD`, 5: number of child channels, 2..16.
- `DATA_W`, 32: job payload and result width.
- `TAG_W`, 4: job tag width, carried through unchanged.
- `ARB_MODE`, 0: 0 = round-robin, 1 = fixed priority (lowest index wins). Applies to both arbiters.
- `CIDX_W`: `$clog2(N_CHILD)`, derived.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  async active-high reset
- `in_valid`  in  1  job offered
- `in_ready`  out  1  job can be accepted
- `in_data`  in  DATA_W  job payload
- `in_tag`  in  TAG_W  job tag
- `ch_start`  out  N_CHILD  one-cycle start pulse per child
- `ch_data`  out  N_CHILD*DATA_W  payload per child, held while busy
- `ch_done`  in  N_CHILD  one-cycle completion pulse per child
- `ch_result`  in  N_CHILD*DATA_W  result, valid with `ch_done`
- `out_valid`  out  1  result available
- `out_ready`  in  1  result consumed
- `out_data`  out  DATA_W  result
- `out_tag`  out  TAG_W  tag of the originating job
- `out_child`  out  CIDX_W  index of the child that produced the result
- `busy_cnt`  out  CIDX_W+1  children in BUSY or PEND
- `jobs_done`  out  16  count of consumed results, wraps
- `err`  out  1  sticky: `ch_done` seen on a child that is not BUSY

## Operation
Each child runs a 3-state FSM:
- IDLE → BUSY when the child is granted an accepted job.
- BUSY → PEND on `ch_done`. The result is captured into that child's result register.
- PEND → IDLE when its result is consumed (`out_valid && out_ready` with `out_child` equal to the child).

Job acceptance:
- `in_ready` = any child IDLE. It is a registered-state function with no dependence on `in_valid`.
- On accept, the dispatch arbiter grants one IDLE child.
- The grant latches `in_data` into that child's `ch_data` slot and `in_tag` into its tag slot.
- In round-robin mode the dispatch pointer moves to grant+1 mod `N_CHILD`.

Result return:
- The return arbiter selects among PEND children. It keeps its own round-robin pointer.
- The selection is locked while `out_valid && !out_ready`. `out_*` stay stable until the handshake completes.

Error handling:
- `ch_done` on a child in IDLE or PEND is ignored. It sets `err`, which clears only on `rst`.

Counters:
- `busy_cnt` is the population count of non-IDLE children.
- `jobs_done` increments by 1 per output handshake and wraps at 2^16.

## Timing
- Reset value of all outputs is 0: `ch_start`, `ch_data`, `out_*`, `busy_cnt`, `jobs_done`, `err`. Exception: `in_ready` is 1 after reset, since all children are IDLE. All FSMs start in IDLE and both arbiter pointers are 0.
- Job accepted in cycle t: `ch_start[k]` is high in t+1 only. `ch_data[k]` is valid from t+1 until the child is released.
- `ch_done[k]` in cycle d: the child is PEND from d+1 and `out_valid` can rise at d+1 at the earliest.
- Output handshake in cycle c: the child is IDLE at c+1, and `in_ready` reflects this at c+1. A child freed in cycle c is never granted in cycle c.
- Simultaneous accept and handshake in the same cycle are independent. Both take effect.
- Simultaneous `ch_done` on several children: all are captured in the same cycle.
- All children BUSY/PEND: `in_ready` = 0. `in_valid` may be held and is not lost.
- Reset mid-operation aborts in-flight jobs. Late `ch_done` pulses after reset set `err`.

## Structure
- Package `tree_node_pkg` holds:
  - the child state enum {IDLE, BUSY, PEND};
  - the `ARB_MODE` constants;
  - a function returning the population count.
- Sub-module `tree_rr_arbiter`, instantiated twice (dispatch and return):
  - parameters `N` and `MODE`;
  - inputs `req[N]`, `advance`;
  - outputs `grant_onehot`, `grant_idx`;
  - registered pointer.

## Test plan
- Reset, then 5 back-to-back jobs, N_CHILD=5, round-robin: `ch_start` pulses on children 0,1,2,3,4 in consecutive cycles, and `in_ready`=0 after the 5th job.
- Children finish in order 3,0,4, one cycle apart, with `out_ready`=1: `out_child` sequence is 3,0,4, `out_tag` matches the tag of each job, and `jobs_done`=3.
- `out_ready` held 0 for 10 cycles with 2 children PEND: `out_*` stay stable. After release, both results are delivered on consecutive cycles.
- `ARB_MODE`=1: free children 1 and 3 together, then send 2 jobs: the first job goes to child 1, the second to child 3.
- `ch_done[2]` pulsed while child 2 is IDLE: `err`=1 next cycle and stays 1, and no `out_valid` is produced.
- Assert `rst` with 3 children BUSY: all outputs return to their reset values immediately, and `in_ready`=1 after `rst` falls.
